key_conditioner: RTL and testbench

//  Input stage upstream of the CPU. Conditions the four raw active-low push-buttons
//  (KEY[3:0]) and the 8-bit data switches into clean, clock-synchronous events.
//  Per key: 2-FF synchroniser, counter debounce and a one-cycle press pulse.
//  KEY[3] press also captures the switch word, giving the CPU's sample/dIn pair.

---
 rtl/key_conditioner_pkg.sv | 27 ++
 rtl/key_conditioner_if.sv | 18 +
 rtl/key_conditioner_channel.sv | 126 ++++++++++++
 rtl/key_conditioner.sv | 54 +++++
 tb/tb_key_conditioner.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner and sibling top-level input stages:
// per-channel state encoding, clock-rate derived defaults and counter sizing.
package key_conditioner_pkg;

  typedef enum logic [1:0] {
    StArm,
    StIdle,
    StPressed
  } ch_state_e;

  localparam int unsigned ClkHz             = 50_000_000;
  localparam int unsigned DefDebounceCycles = ClkHz / 100;  // 10 ms
  localparam int unsigned DefRepeatDelay    = ClkHz / 2;    // 500 ms
  localparam int unsigned DefRepeatPeriod   = ClkHz / 10;   // 100 ms

  // Width of a saturating channel counter. The +2 leaves room for the post-reset
  // release count of DEBOUNCE_CYCLES+1 used in the ARM state.
  function automatic int unsigned cnt_width(input int unsigned db, input int unsigned rd,
                                            input int unsigned rp);
    int unsigned m;
    m = db;
    if (rd > m) m = rd;
    if (rp > m) m = rp;
    return $clog2(m + 2);
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw buttons/switches in, debounced levels, pulses and the
// captured switch word out. The slave modport is the conditioner itself.
interface key_conditioner_if #(
  parameter int unsigned N_KEYS = 4,
  parameter int unsigned DATA_W = 8
);
  logic [N_KEYS-1:0] keys_n;
  logic [DATA_W-1:0] dIn_raw;
  logic [N_KEYS-1:0] held;
  logic [N_KEYS-1:0] press;
  logic [DATA_W-1:0] dOut;
  logic              sample;

  modport master (output keys_n, output dIn_raw,
                  input held, input press, input dOut, input sample);
  modport slave  (input keys_n, input dIn_raw,
                  output held, output press, output dOut, output sample);
endinterface

// File: rtl/key_conditioner_channel.sv
// One key channel: 2-FF synchroniser, counter debounce, ARM/IDLE/PRESSED FSM and,
// when AUTO_REPEAT_EN is defined, hold-to-repeat. REPEAT_DELAY = 0 disables repeat
// for this channel (used for the sample key).
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic held_o,
  output logic press_o,
  output logic press_next_o
);
  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CntW-1:0] DbLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] ArmLast = CntW'(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  logic            sync1_q, s_q;
  logic            held_q, held_d, press_q, press_d;
  logic            flip, arm_done;
  logic [CntW-1:0] cnt_q, cnt_d;
  ch_state_e       state_q, state_d;

`ifdef AUTO_REPEAT_EN
  localparam bit              RptEn     = (REPEAT_DELAY != 0);
  localparam logic [CntW-1:0] RptLast   = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RptReload = CntW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [CntW-1:0] rpt_q, rpt_d;

  // Hold-time counter for auto-repeat; only non-zero while PRESSED.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rpt_q <= '0;
    else         rpt_q <= rpt_d;
  end
`endif

  // Synchronise the inverted button; reset value means "released".
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= ~key_n_i;
      s_q     <= sync1_q;
    end
  end

  // Debounce: count stable disagreement with held; in ARM also count stable release.
  // ArmLast covers the two reset-valued synchroniser stages, so ARM ends only after
  // DEBOUNCE_CYCLES genuinely sampled released cycles.
  always_comb begin
    flip     = 1'b0;
    held_d   = held_q;
    cnt_d    = '0;
    arm_done = (state_q == StArm) && !s_q && !held_q && (cnt_q == ArmLast);
    if ((s_q != held_q) && (cnt_q == DbLast)) begin
      flip   = 1'b1;
      held_d = s_q;
    end else if (arm_done || (sync1_q != s_q)) begin
      // s is about to change: any run in progress ends here.
      cnt_d = '0;
    end else if ((s_q != held_q) || ((state_q == StArm) && !held_q)) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Channel FSM: press pulse on accepted press (and repeats); nothing on release.
  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_d   = '0;
`endif
    unique case (state_q)
      StArm: begin
        if (arm_done || (flip && held_q)) state_d = StIdle;
      end
      StIdle: begin
        if (flip && !held_q) begin
          state_d = StPressed;
          press_d = 1'b1;
        end
      end
      StPressed: begin
        if (flip && held_q) begin
          state_d = StIdle;
`ifdef AUTO_REPEAT_EN
        end else if (RptEn) begin
          if (rpt_q == RptLast) begin
            press_d = 1'b1;
            rpt_d   = RptReload;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = StArm;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StArm;
      held_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held_o       = held_q;
  assign press_o      = press_q;
  assign press_next_o = press_d;

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner top: N_KEYS debounced key channels plus the synchronised switch
// word, captured into dOut on each press of the last (sample) key.
// Optional feature: define AUTO_REPEAT_EN for hold-to-repeat on non-sample keys.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input logic             clock,
  input logic             reset,
  key_conditioner_if.slave bus
);
  logic [N_KEYS-1:0] held, press, press_next;
  logic [DATA_W-1:0] din_sync1_q, din_s_q, dout_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    // The sample key never repeats: one capture per physical press.
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   ((i == N_KEYS - 1) ? 0 : REPEAT_DELAY),
      .REPEAT_PERIOD  ((i == N_KEYS - 1) ? 0 : REPEAT_PERIOD)
    ) u_ch (
      .clk_i       (clock),
      .rst_ni      (reset),
      .key_n_i     (bus.keys_n[i]),
      .held_o      (held[i]),
      .press_o     (press[i]),
      .press_next_o(press_next[i])
    );
  end

  // Switch synchroniser and capture, aligned with the sample key's press pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      din_sync1_q <= '0;
      din_s_q     <= '0;
      dout_q      <= '0;
    end else begin
      din_sync1_q <= bus.dIn_raw;
      din_s_q     <= din_sync1_q;
      if (press_next[N_KEYS-1]) dout_q <= din_s_q;
    end
  end

  assign bus.held   = held;
  assign bus.press  = press;
  assign bus.dOut   = dout_q;
  assign bus.sample = press[N_KEYS-1];

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key bounce/press and
// reset traffic, checked every cycle against an event-level model of the keys.
module tb_key_conditioner;
  localparam int unsigned NK = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_conditioner_if #(.N_KEYS(NK), .DATA_W(DW)) bus ();

  key_conditioner #(
    .N_KEYS(NK), .DATA_W(DW), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model state
  logic [NK-1:0] kh1, kh2;
  logic [DW-1:0] dh1, dh2, m_dout;
  bit            m_held[NK], m_armed[NK], m_press[NK];
  bit            m_sample;
  int            mis_run[NK], arm_run[NK], hold_t[NK], arm_cyc[NK], dut_cnt[NK];
  int            p0_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge. A key's synced level is its raw value two
  // edges ago; a change is accepted after D consecutive disagreeing samples.
  task automatic model_step();
    bit s, hp, fu, fd;
    if (!rst_n) begin
      kh1 = '1; kh2 = '1; dh1 = '0; dh2 = '0; m_dout = '0; m_sample = 1'b0; cyc = 0;
      p0_q.delete();
      for (int i = 0; i < NK; i++) begin
        m_held[i] = 0; m_armed[i] = 0; m_press[i] = 0;
        mis_run[i] = 0; arm_run[i] = 0; hold_t[i] = 0; arm_cyc[i] = -1;
      end
      return;
    end
    cyc++;
    for (int i = 0; i < NK; i++) begin
      s  = ~kh2[i];
      hp = m_held[i];
      fu = 0;
      fd = 0;
      m_press[i] = 0;
      if (s != hp) begin
        mis_run[i]++;
        if (mis_run[i] == D) begin
          m_held[i]  = s;
          mis_run[i] = 0;
          if (s) fu = 1;
          else   fd = 1;
        end
      end else begin
        mis_run[i] = 0;
      end
      if (!m_armed[i]) begin
        // Not armed until a release is seen: D+2 released samples from reset, or a
        // debounced release of a key that was down through reset.
        if (fd) begin
          m_armed[i] = 1; arm_cyc[i] = cyc;
        end else if (!s && !hp) begin
          arm_run[i]++;
          if (arm_run[i] == D + 2) begin
            m_armed[i] = 1; arm_cyc[i] = cyc; arm_run[i] = 0;
          end
        end else begin
          arm_run[i] = 0;
        end
      end else if (fu) begin
        m_press[i] = 1;
        hold_t[i]  = 0;
      end else if (fd) begin
        hold_t[i] = 0;
`ifdef AUTO_REPEAT_EN
      end else if (m_held[i]) begin
        hold_t[i]++;
        if ((i != NK - 1) && (hold_t[i] >= RD) && (((hold_t[i] - RD) % RP) == 0))
          m_press[i] = 1;
`endif
      end
      if ((i == 0) && m_press[0]) p0_q.push_back(cyc);
    end
    m_sample = m_press[NK-1];
    if (m_sample) m_dout = dh2;
    kh2 = kh1; kh1 = bus.keys_n;
    dh2 = dh1; dh1 = bus.dIn_raw;
  endtask

  // Per-cycle compare, just after each active edge.
  initial begin
    logic [NK-1:0] mh, mp;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < NK; i++) begin
        mh[i] = m_held[i];
        mp[i] = m_press[i];
      end
      chk("held", 32'(bus.held), 32'(mh));
      chk("press", 32'(bus.press), 32'(mp));
      chk("dOut", 32'(bus.dOut), 32'(m_dout));
      chk("sample", 32'(bus.sample), 32'(m_sample));
      for (int i = 0; i < NK; i++) begin
        if (!rst_n) dut_cnt[i] = 0;
        else if (bus.press[i]) dut_cnt[i]++;
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base, exp_n, hold_left[NK];
    bus.keys_n  = '1;
    bus.dIn_raw = '0;
    rst_n       = 1'b0;
    wait_n(3);
    chk("rst_held", 32'(bus.held), 0);
    chk("rst_press", 32'(bus.press), 0);
    chk("rst_dOut", 32'(bus.dOut), 0);
    chk("rst_sample", 32'(bus.sample), 0);
    rst_n = 1'b1;
    wait_n(8);
    chk("arm_cycle_k0", arm_cyc[0], 6);
    chk("arm_cycle_k3", arm_cyc[3], 6);

    // Single held press on key 0
    base = cyc;
    bus.keys_n[0] = 1'b0;
    wait_n(30);
    bus.keys_n[0] = 1'b1;
    wait_n(12);
`ifdef AUTO_REPEAT_EN
    exp_n = 8;
    if (p0_q.size() >= 3) begin
      chk("k0_second_pulse", p0_q[1] - base, 16);
      chk("k0_third_pulse", p0_q[2] - base, 19);
    end
`else
    exp_n = 1;
`endif
    chk("k0_model_pulses", p0_q.size(), exp_n);
    if (p0_q.size() > 0) chk("k0_first_pulse", p0_q[0] - base, 6);
    chk("k0_dut_pulses", dut_cnt[0], exp_n);
    chk("k0_released", 32'(bus.held[0]), 0);

    // Short glitch on key 1
    bus.keys_n[1] = 1'b0;
    wait_n(3);
    bus.keys_n[1] = 1'b1;
    wait_n(15);
    chk("k1_glitch_pulses", dut_cnt[1], 0);
    chk("k1_glitch_held", 32'(bus.held[1]), 0);

    // Sample capture, then switch change alone
    bus.dIn_raw = 8'hA5;
    wait_n(3);
    bus.keys_n[3] = 1'b0;
    wait_n(10);
    chk("sample_dOut", 32'(bus.dOut), 32'h A5);
    chk("sample_pulses", dut_cnt[3], 1);
    bus.dIn_raw = 8'h3C;
    wait_n(10);
    chk("dOut_hold", 32'(bus.dOut), 32'h A5);
    bus.keys_n[3] = 1'b1;
    wait_n(10);
    chk("sample_single", dut_cnt[3], 1);

    // Key 2 down through reset: no phantom press, then one real press
    rst_n = 1'b0;
    bus.keys_n[2] = 1'b0;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(15);
    chk("k2_phantom", dut_cnt[2], 0);
    bus.keys_n[2] = 1'b1;
    wait_n(12);
    bus.keys_n[2] = 1'b0;
    wait_n(12);
    chk("k2_real_press", dut_cnt[2], 1);
    bus.keys_n[2] = 1'b1;
    wait_n(12);

    // Reset mid-debounce (key 0) and mid-hold (key 1)
    bus.keys_n[1] = 1'b0;
    wait_n(10);
    bus.keys_n[0] = 1'b0;
    wait_n(3);
    rst_n = 1'b0;
    wait_n(2);
    bus.keys_n = '1;
    rst_n = 1'b1;
    wait_n(15);
    chk("rst_mid_k0", dut_cnt[0], 0);
    chk("rst_mid_k1", dut_cnt[1], 0);

    // Random bounce/press/reset traffic
    for (int i = 0; i < NK; i++) hold_left[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      for (int i = 0; i < NK; i++) begin
        if (hold_left[i] == 0) begin
          bus.keys_n[i] = 1'($urandom_range(0, 1));
          hold_left[i]  = int'($urandom_range(1, 14));
        end
        hold_left[i]--;
      end
      if ($urandom_range(0, 7) == 0) bus.dIn_raw = 8'($urandom);
    end
    wait_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
